rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 The parameter ROB_DEPTH SHALL default to 16 and SHALL set the number of reorder-buffer entries (power of two, at least 4).
REQ-002 The parameter TAG_WIDTH SHALL default to $clog2(ROB_DEPTH) and SHALL set the width of the ROB tag, which is the entry index.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  global pipeline flush.
REQ-006 cache_stall  in  1  freezes allocation and commit.
REQ-007 alloc_0_valid, alloc_1_valid  in  1 each  rename-slot allocation requests.
REQ-008 alloc_0_rd, alloc_1_rd  in  $clog2(ARCH_REGS) each  architectural destination register; x0 means no writeback to the PRF.
REQ-009 alloc_0_tag, alloc_1_tag  out  TAG_WIDTH each  tag assigned to slot 0/1; feeds the rat_*_write_port tag.
REQ-010 alloc_ready  out  1  high when at least 2 entries are free.
REQ-011 wb_0, wb_1  in  struct {valid, tag, data[CPU_DATA_BITS]} each  execution writeback.
REQ-012 commit_0_write_port, commit_1_write_port  out  prf_commit_write_port_t {we, addr, tag, data} each  in-order retirement to the PRF.
REQ-013 rob_empty  out  1  high when no entries are valid.

Function
REQ-014 Entry state SHALL be {valid, done, rd, data}; head_ptr and tail_ptr SHALL each be TAG_WIDTH+1 bits, with the MSB as the wrap bit.
REQ-015 Occupancy SHALL equal tail_ptr-head_ptr; the buffer is full when the occupancy equals ROB_DEPTH and empty when head_ptr==tail_ptr.
REQ-016 alloc_0_tag SHALL equal tail_ptr[TAG_WIDTH-1:0], and alloc_1_tag SHALL equal (tail_ptr+1) mod ROB_DEPTH; both outputs are combinational.
REQ-017 Allocation SHALL occur only when alloc_ready=1 and cache_stall=0 and flush=0.
REQ-018 When alloc_0_valid=1, the block SHALL write the entry at tail with valid=1, done=0, rd=alloc_0_rd.
REQ-019 When alloc_0_valid=1 and alloc_1_valid=1, the block SHALL also write entry tail+1 and advance the tail by 2; with only alloc_0_valid=1 it SHALL advance the tail by 1.
REQ-020 alloc_1_valid without alloc_0_valid SHALL be ignored.
REQ-021 A writeback with valid=1 to an entry with valid=1 SHALL set done=1 and latch the data; it SHALL be accepted even when cache_stall=1.
REQ-022 A writeback to an entry with valid=0 SHALL be ignored.
REQ-023 When wb_0 and wb_1 carry the same tag, the block SHALL take the data from wb_1.
REQ-024 commit_0_write_port.we SHALL be 1 when the head entry has valid=1 and done=1 and cache_stall=0 and flush=0.
REQ-025 commit_0_write_port SHALL carry addr=rd, tag=head index, data=entry data; all commit outputs are combinational from registered state.
REQ-026 commit_1 SHALL fire only when commit_0 fires and entry head+1 has valid=1 and done=1; there is never an out-of-order commit.
REQ-027 A committed entry SHALL be cleared (valid=0, done=0), and head SHALL advance by the number of commits.
REQ-028 An entry with rd=0 SHALL still commit and drive we=1 with addr=0, because the PRF discards writes to x0.
REQ-029 Latency: a writeback at edge N SHALL make commit visible in cycle N+1 at the earliest; a writeback and a commit of the same entry in one cycle SHALL NOT occur.
REQ-030 Simultaneous allocation and commit SHALL both take effect in the same cycle, and the occupancy SHALL change by allocs minus commits.
REQ-031 Pointer wrap-around SHALL be modulo 2*ROB_DEPTH on the pointer and modulo ROB_DEPTH on the index.
REQ-032 flush SHALL clear every valid and done bit and set head_ptr=tail_ptr=0 at the next edge; flush SHALL take priority over alloc, writeback and commit in that cycle.
REQ-033 cache_stall=1 SHALL hold the head, the tail and the allocated entries, and SHALL force commit_*.we=0.

Reset
REQ-034 On rst, the block SHALL set all valid and done bits to 0, head_ptr=tail_ptr=0 and data to 0; rst SHALL take priority over flush.
REQ-035 Outputs after reset SHALL be: alloc_ready=1, rob_empty=1, commit_*.we=0, alloc_0_tag=0, alloc_1_tag=1.

Structure
REQ-036 ROB_DEPTH, TAG_WIDTH, the wb port struct type and prf_commit_write_port_t SHALL reside in uarch_pkg.
REQ-037 The design SHALL be a single module with no sub-modules; the entry array SHALL be flops, not SRAM.

Verification
REQ-038 Reset, then allocate 2 entries (rd=5, rd=6) -> tags 0 and 1; writeback tag1 data=0xB, then tag0 data=0xA -> no commit until tag0 is done, then both commit in the same cycle with we=1/1, addr 5/6, data 0xA/0xB.
REQ-039 Allocate 16 entries -> alloc_ready=0 at occupancy 15 and 16; commit 2 -> alloc_ready=1; allocating 2 more -> tags 0 and 1 after wrap.
REQ-040 Assert flush with 7 entries valid -> next cycle rob_empty=1, tags restart at 0, and a stale writeback to tag 3 is ignored.
REQ-041 Assert cache_stall for 3 cycles with head done -> we=0 throughout, writebacks still mark entries done, and the commit occurs on the first unstalled cycle.
REQ-042 Head done, head+1 not done -> only commit_0 fires; head advances by 1.
REQ-043 Allocation and commit of 2 each in the same cycle at occupancy 14 -> occupancy stays 14 and alloc_ready=1.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and sizes for the reorder buffer and its
// neighbours (rename, PRF). The ROB tag is the entry index.
package uarch_pkg;

  localparam int ROB_DEPTH     = 16;
  localparam int TAG_WIDTH     = $clog2(ROB_DEPTH);
  localparam int ARCH_REGS     = 32;
  localparam int REG_ADDR_W    = $clog2(ARCH_REGS);
  localparam int CPU_DATA_BITS = 32;

  typedef logic [TAG_WIDTH-1:0]     rob_tag_t;
  typedef logic [REG_ADDR_W-1:0]    arch_reg_t;
  typedef logic [CPU_DATA_BITS-1:0] cpu_data_t;

  // Execution-unit writeback into the ROB.
  typedef struct packed {
    logic      valid;
    rob_tag_t  tag;
    cpu_data_t data;
  } rob_wb_t;

  // In-order retirement write into the physical register file.
  typedef struct packed {
    logic      we;
    arch_reg_t addr;
    rob_tag_t  tag;
    cpu_data_t data;
  } prf_commit_write_port_t;

endpackage

// File: rtl/rob.sv
// Two-wide reorder buffer. Entries are allocated in order at the tail by the
// rename stage, marked done out of order by execution writebacks, and retired
// in order from the head (up to two per cycle) into the PRF.
//
// Allocation handshake: the rename stage presents alloc_0_valid (and
// optionally alloc_1_valid); the request transfers at a rising edge exactly
// when alloc_0_valid && alloc_ready && !cache_stall && !flush. alloc_ready is
// a pure function of occupancy and never depends on alloc_*_valid, so rename
// may look at it before deciding to request. There is no back-pressure on
// writebacks or commits: a valid writeback is always taken, and the PRF
// always accepts a commit whose we is high.
module rob #(
  parameter int ROB_DEPTH = uarch_pkg::ROB_DEPTH,
  parameter int TAG_WIDTH = $clog2(ROB_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              cache_stall,
  input  logic                              alloc_0_valid,
  input  logic                              alloc_1_valid,
  input  logic [uarch_pkg::REG_ADDR_W-1:0]  alloc_0_rd,
  input  logic [uarch_pkg::REG_ADDR_W-1:0]  alloc_1_rd,
  output logic [TAG_WIDTH-1:0]              alloc_0_tag,
  output logic [TAG_WIDTH-1:0]              alloc_1_tag,
  output logic                              alloc_ready,
  input  uarch_pkg::rob_wb_t                wb_0,
  input  uarch_pkg::rob_wb_t                wb_1,
  output uarch_pkg::prf_commit_write_port_t commit_0_write_port,
  output uarch_pkg::prf_commit_write_port_t commit_1_write_port,
  output logic                              rob_empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = TAG_WIDTH + 1;
  localparam int RD_W  = uarch_pkg::REG_ADDR_W;
  localparam int DW    = uarch_pkg::CPU_DATA_BITS;
  // Allocation needs room for a full pair, so it stops at ROB_DEPTH-1 used.
  localparam logic [PTR_W-1:0] READY_LIMIT = PTR_W'(ROB_DEPTH - 2);

  // Entry state: flop array, one field vector per attribute.
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q,  done_d;
  logic [RD_W-1:0]      rd_q   [ROB_DEPTH];
  logic [RD_W-1:0]      rd_d   [ROB_DEPTH];
  logic [DW-1:0]        data_q [ROB_DEPTH];
  logic [DW-1:0]        data_d [ROB_DEPTH];

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;

  logic [PTR_W-1:0]     occupancy;
  logic [TAG_WIDTH-1:0] head_idx, head_idx_1;
  logic [TAG_WIDTH-1:0] tail_idx, tail_idx_1;
  logic                 alloc_fire;
  logic                 alloc_pair;
  logic                 commit_0_fire;
  logic                 commit_1_fire;
  logic [1:0]           n_commit;

  // Occupancy, free-space status and the tags offered to rename.
  always_comb begin
    occupancy   = tail_q - head_q;
    rob_empty   = (head_q == tail_q);
    alloc_ready = (occupancy <= READY_LIMIT);
    head_idx    = head_q[TAG_WIDTH-1:0];
    head_idx_1  = head_idx + TAG_WIDTH'(1);
    tail_idx    = tail_q[TAG_WIDTH-1:0];
    tail_idx_1  = tail_idx + TAG_WIDTH'(1);
    alloc_0_tag = tail_idx;
    alloc_1_tag = tail_idx_1;
  end

  // Allocation and commit qualification; slot 1 only ever rides with slot 0.
  always_comb begin
    alloc_fire    = alloc_0_valid && alloc_ready && !cache_stall && !flush;
    alloc_pair    = alloc_fire && alloc_1_valid;
    commit_0_fire = valid_q[head_idx] && done_q[head_idx] && !cache_stall && !flush;
    commit_1_fire = commit_0_fire && valid_q[head_idx_1] && done_q[head_idx_1];
    n_commit      = commit_1_fire ? 2'd2 : (commit_0_fire ? 2'd1 : 2'd0);
  end

  // Retirement ports are driven purely from registered entry state, so a
  // writeback can make its entry visible here no earlier than the next cycle.
  always_comb begin
    commit_0_write_port      = '0;
    commit_0_write_port.we   = commit_0_fire;
    commit_0_write_port.addr = rd_q[head_idx];
    commit_0_write_port.tag  = head_idx;
    commit_0_write_port.data = data_q[head_idx];

    commit_1_write_port      = '0;
    commit_1_write_port.we   = commit_1_fire;
    commit_1_write_port.addr = rd_q[head_idx_1];
    commit_1_write_port.tag  = head_idx_1;
    commit_1_write_port.data = data_q[head_idx_1];
  end

  // Next entry/pointer state: flush wins outright; otherwise writebacks,
  // then commit clears, then allocation. Commit and allocation never touch
  // the same index because allocation needs two free slots.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      // wb_1 is applied second so it wins when both ports carry one tag.
      if (wb_0.valid && valid_q[wb_0.tag]) begin
        done_d[wb_0.tag] = 1'b1;
        data_d[wb_0.tag] = wb_0.data;
      end
      if (wb_1.valid && valid_q[wb_1.tag]) begin
        done_d[wb_1.tag] = 1'b1;
        data_d[wb_1.tag] = wb_1.data;
      end

      if (commit_0_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
      end
      if (commit_1_fire) begin
        valid_d[head_idx_1] = 1'b0;
        done_d[head_idx_1]  = 1'b0;
      end
      head_d = head_q + {{(PTR_W-2){1'b0}}, n_commit};

      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        rd_d[tail_idx]    = alloc_0_rd;
        if (alloc_pair) begin
          valid_d[tail_idx_1] = 1'b1;
          done_d[tail_idx_1]  = 1'b0;
          rd_d[tail_idx_1]    = alloc_1_rd;
          tail_d              = tail_q + PTR_W'(2);
        end else begin
          tail_d = tail_q + PTR_W'(1);
        end
      end
    end
  end

  // State registers; reset clears everything including the data payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: allocation, out-of-order writeback,
// in-order dual commit, wrap-around, flush and cache-stall behaviour.
module tb_rob;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                              flush;
  logic                              cache_stall;
  logic                              alloc_0_valid;
  logic                              alloc_1_valid;
  logic [uarch_pkg::REG_ADDR_W-1:0]  alloc_0_rd;
  logic [uarch_pkg::REG_ADDR_W-1:0]  alloc_1_rd;
  logic [3:0]                        alloc_0_tag;
  logic [3:0]                        alloc_1_tag;
  logic                              alloc_ready;
  uarch_pkg::rob_wb_t                wb_0;
  uarch_pkg::rob_wb_t                wb_1;
  uarch_pkg::prf_commit_write_port_t commit_0_write_port;
  uarch_pkg::prf_commit_write_port_t commit_1_write_port;
  logic                              rob_empty;

  rob dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .cache_stall         (cache_stall),
    .alloc_0_valid       (alloc_0_valid),
    .alloc_1_valid       (alloc_1_valid),
    .alloc_0_rd          (alloc_0_rd),
    .alloc_1_rd          (alloc_1_rd),
    .alloc_0_tag         (alloc_0_tag),
    .alloc_1_tag         (alloc_1_tag),
    .alloc_ready         (alloc_ready),
    .wb_0                (wb_0),
    .wb_1                (wb_1),
    .commit_0_write_port (commit_0_write_port),
    .commit_1_write_port (commit_1_write_port),
    .rob_empty           (rob_empty)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after the rising edge; checks run 1ns later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    flush         = 1'b0;
    cache_stall   = 1'b0;
    alloc_0_valid = 1'b0;
    alloc_1_valid = 1'b0;
    alloc_0_rd    = '0;
    alloc_1_rd    = '0;
    wb_0          = '0;
    wb_1          = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic set_alloc(input logic v0, input logic v1, input logic [4:0] rd0, input logic [4:0] rd1);
    alloc_0_valid = v0;
    alloc_1_valid = v1;
    alloc_0_rd    = rd0;
    alloc_1_rd    = rd1;
  endtask

  task automatic alloc_pair(input logic [4:0] rd0, input logic [4:0] rd1);
    set_alloc(1'b1, 1'b1, rd0, rd1);
    tick();
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic alloc_one(input logic [4:0] rd0);
    set_alloc(1'b1, 1'b0, rd0, 5'd0);
    tick();
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic set_wb0(input logic [3:0] t, input logic [31:0] d);
    wb_0 = '{valid: 1'b1, tag: t, data: d};
  endtask

  task automatic set_wb1(input logic [3:0] t, input logic [31:0] d);
    wb_1 = '{valid: 1'b1, tag: t, data: d};
  endtask

  task automatic wb_cycle();
    tick();
    wb_0 = '0;
    wb_1 = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    do_reset();

    // Reset state
    check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check_eq("rst_rob_empty",   64'(rob_empty), 64'd1);
    check_eq("rst_c0_we",       64'(commit_0_write_port.we), 64'd0);
    check_eq("rst_c1_we",       64'(commit_1_write_port.we), 64'd0);
    check_eq("rst_tag0",        64'(alloc_0_tag), 64'd0);
    check_eq("rst_tag1",        64'(alloc_1_tag), 64'd1);

    // Pair allocate, out-of-order writeback, dual commit
    set_alloc(1'b1, 1'b1, 5'd5, 5'd6);
    settle();
    check_eq("s1_tag0", 64'(alloc_0_tag), 64'd0);
    check_eq("s1_tag1", 64'(alloc_1_tag), 64'd1);
    tick();
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("s1_not_empty", 64'(rob_empty), 64'd0);
    check_eq("s1_next_tag",  64'(alloc_0_tag), 64'd2);
    set_wb1(4'd1, 32'hB);
    wb_cycle();
    check_eq("s1_no_commit_c0", 64'(commit_0_write_port.we), 64'd0);
    check_eq("s1_no_commit_c1", 64'(commit_1_write_port.we), 64'd0);
    set_wb0(4'd0, 32'hA);
    wb_cycle();
    check_eq("s1_c0_we",   64'(commit_0_write_port.we), 64'd1);
    check_eq("s1_c1_we",   64'(commit_1_write_port.we), 64'd1);
    check_eq("s1_c0_addr", 64'(commit_0_write_port.addr), 64'd5);
    check_eq("s1_c1_addr", 64'(commit_1_write_port.addr), 64'd6);
    check_eq("s1_c0_data", 64'(commit_0_write_port.data), 64'hA);
    check_eq("s1_c1_data", 64'(commit_1_write_port.data), 64'hB);
    check_eq("s1_c0_tag",  64'(commit_0_write_port.tag), 64'd0);
    check_eq("s1_c1_tag",  64'(commit_1_write_port.tag), 64'd1);
    tick();
    check_eq("s1_empty_after", 64'(rob_empty), 64'd1);
    check_eq("s1_c0_idle",     64'(commit_0_write_port.we), 64'd0);

    // Fill to 16, drain to 13, wrap tags
    do_reset();
    for (int p = 0; p < 8; p++) begin
      check_eq("s2_fill_tag0", 64'(alloc_0_tag), 64'(2 * p));
      check_eq("s2_fill_ready", 64'(alloc_ready), 64'd1);
      alloc_pair(5'(p + 1), 5'(p + 9));
    end
    check_eq("s2_full_ready", 64'(alloc_ready), 64'd0);
    check_eq("s2_full_tag0",  64'(alloc_0_tag), 64'd0);
    set_wb0(4'd0, 32'h100);
    wb_cycle();
    check_eq("s2_c0_only_we0", 64'(commit_0_write_port.we), 64'd1);
    check_eq("s2_c0_only_we1", 64'(commit_1_write_port.we), 64'd0);
    check_eq("s2_c0_addr",     64'(commit_0_write_port.addr), 64'd1);
    tick();
    check_eq("s2_occ15_ready", 64'(alloc_ready), 64'd0);
    alloc_pair(5'd20, 5'd21);
    check_eq("s2_blocked_tag", 64'(alloc_0_tag), 64'd0);
    set_wb0(4'd1, 32'h101);
    set_wb1(4'd2, 32'h102);
    wb_cycle();
    check_eq("s2_c0_tag", 64'(commit_0_write_port.tag), 64'd1);
    check_eq("s2_c1_tag", 64'(commit_1_write_port.tag), 64'd2);
    check_eq("s2_c1_we",  64'(commit_1_write_port.we), 64'd1);
    tick();
    check_eq("s2_occ13_ready", 64'(alloc_ready), 64'd1);
    set_alloc(1'b1, 1'b1, 5'd22, 5'd23);
    settle();
    check_eq("s2_wrap_tag0", 64'(alloc_0_tag), 64'd0);
    check_eq("s2_wrap_tag1", 64'(alloc_1_tag), 64'd1);
    tick();
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("s2_occ15_again", 64'(alloc_ready), 64'd0);
    check_eq("s2_after_wrap_tag", 64'(alloc_0_tag), 64'd2);

    // Alloc 2 and commit 2 together at occupancy 14
    do_reset();
    for (int p = 0; p < 7; p++) alloc_pair(5'(2 * p + 1), 5'(2 * p + 2));
    set_wb0(4'd0, 32'h200);
    set_wb1(4'd1, 32'h201);
    wb_cycle();
    set_alloc(1'b1, 1'b1, 5'd30, 5'd31);
    settle();
    check_eq("s3_c0_we",  64'(commit_0_write_port.we), 64'd1);
    check_eq("s3_c1_we",  64'(commit_1_write_port.we), 64'd1);
    check_eq("s3_tag0",   64'(alloc_0_tag), 64'd14);
    check_eq("s3_tag1",   64'(alloc_1_tag), 64'd15);
    check_eq("s3_ready",  64'(alloc_ready), 64'd1);
    tick();
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("s3_ready_after", 64'(alloc_ready), 64'd1);
    check_eq("s3_tail_wrap",   64'(alloc_0_tag), 64'd0);
    check_eq("s3_head_not_done", 64'(commit_0_write_port.we), 64'd0);

    // Flush with 7 valid entries; flush beats a same-cycle alloc
    do_reset();
    for (int p = 0; p < 3; p++) alloc_pair(5'(p + 1), 5'(p + 4));
    alloc_one(5'd7);
    check_eq("s4_tag_before", 64'(alloc_0_tag), 64'd7);
    set_wb0(4'd3, 32'h333);
    wb_cycle();
    flush = 1'b1;
    set_alloc(1'b1, 1'b1, 5'd8, 5'd9);
    tick();
    flush = 1'b0;
    set_alloc(1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("s4_empty",  64'(rob_empty), 64'd1);
    check_eq("s4_tag0",   64'(alloc_0_tag), 64'd0);
    check_eq("s4_tag1",   64'(alloc_1_tag), 64'd1);
    check_eq("s4_ready",  64'(alloc_ready), 64'd1);
    set_wb0(4'd3, 32'h3333);
    wb_cycle();
    check_eq("s4_stale_wb_empty", 64'(rob_empty), 64'd1);
    alloc_pair(5'd9, 5'd10);
    check_eq("s4_no_commit", 64'(commit_0_write_port.we), 64'd0);
    check_eq("s4_refill_tag", 64'(alloc_0_tag), 64'd2);
    set_wb0(4'd0, 32'h99);
    wb_cycle();
    check_eq("s4_c0_addr", 64'(commit_0_write_port.addr), 64'd9);
    check_eq("s4_c0_data", 64'(commit_0_write_port.data), 64'h99);

    // cache_stall for 3 cycles with the head done
    do_reset();
    alloc_pair(5'd3, 5'd4);
    set_wb0(4'd0, 32'h50);
    wb_cycle();
    cache_stall = 1'b1;
    settle();
    check_eq("s5_stall_we_0", 64'(commit_0_write_port.we), 64'd0);
    set_wb0(4'd1, 32'h51);
    wb_cycle();
    check_eq("s5_stall_we_1", 64'(commit_0_write_port.we), 64'd0);
    alloc_one(5'd12);
    check_eq("s5_stall_we_2", 64'(commit_0_write_port.we), 64'd0);
    check_eq("s5_stall_tail", 64'(alloc_0_tag), 64'd2);
    tick();
    cache_stall = 1'b0;
    settle();
    check_eq("s5_c0_we",   64'(commit_0_write_port.we), 64'd1);
    check_eq("s5_c1_we",   64'(commit_1_write_port.we), 64'd1);
    check_eq("s5_c0_data", 64'(commit_0_write_port.data), 64'h50);
    check_eq("s5_c1_data", 64'(commit_1_write_port.data), 64'h51);
    tick();
    check_eq("s5_empty", 64'(rob_empty), 64'd1);

    // Head done, head+1 not done; rd=0 still commits
    do_reset();
    alloc_pair(5'd7, 5'd0);
    set_wb0(4'd0, 32'h70);
    wb_cycle();
    check_eq("s6_c0_we", 64'(commit_0_write_port.we), 64'd1);
    check_eq("s6_c1_we", 64'(commit_1_write_port.we), 64'd0);
    tick();
    check_eq("s6_not_empty", 64'(rob_empty), 64'd0);
    check_eq("s6_head_wait", 64'(commit_0_write_port.we), 64'd0);
    set_wb0(4'd1, 32'h71);
    wb_cycle();
    check_eq("s6_x0_we",   64'(commit_0_write_port.we), 64'd1);
    check_eq("s6_x0_addr", 64'(commit_0_write_port.addr), 64'd0);
    check_eq("s6_x0_tag",  64'(commit_0_write_port.tag), 64'd1);
    check_eq("s6_x0_data", 64'(commit_0_write_port.data), 64'h71);
    tick();
    check_eq("s6_empty", 64'(rob_empty), 64'd1);

    // Both writeback ports hit one tag: wb_1 data wins
    alloc_one(5'd2);
    set_wb0(4'd2, 32'hAA);
    set_wb1(4'd2, 32'hBB);
    wb_cycle();
    check_eq("s7_same_tag_we",   64'(commit_0_write_port.we), 64'd1);
    check_eq("s7_same_tag_data", 64'(commit_0_write_port.data), 64'hBB);
    tick();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
